fft_butterfly_r2: RTL and testbench
===================================

// Module: fft_butterfly_r2
// PURPOSE
//  Radix-2 complex butterfly unit for the FFT datapath. It consumes operand pairs (A,B) that the
//  register file streams out on its two FFT word read ports. It returns X=A+W*B and Y=A-W*B on
//  the RF word write ports. Twiddle W comes from an internal writable table, indexed by
//  stage/butterfly counters that track the AGU read sequence. One butterfly per cycle, fixed latency.
// PARAMETERS
//  WORD_BITWIDTH  32  packed complex word {re[31:16], im[15:0]}, signed Q1.15 each
//  MAX_LOG2N      7   largest supported FFT size is 2**MAX_LOG2N points (= RF_DEPTH)
//  TW_DEPTH       64  twiddle entries, 2**(MAX_LOG2N-1); tw[k] = W_{2**MAX_LOG2N}^k
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               asynchronous, active-low reset
//  cfg_en       in   1               load config, start new FFT run
//  cfg_log2n    in   4               log2 of FFT points for this run
//  cfg_inverse  in   1               1 = use conj(W) (IFFT)
//  cfg_scale    in   1               1 = divide X,Y by 2 (per-stage scaling)
//  tw_we        in   1               twiddle table write enable
//  tw_waddr     in   $clog2(TW_DEPTH) twiddle write address
//  tw_wdata     in   WORD_BITWIDTH   twiddle value {re,im}
//  in_valid     in   1               operand pair valid (tied to RF word read enables)
//  in_a, in_b   in   WORD_BITWIDTH   operands A, B
//  out_valid    out  1               X/Y valid (drives RF word write enables)
//  out_x, out_y out  WORD_BITWIDTH   results X, Y
//  busy         out  1               FSM not IDLE
//  done         out  1               1-cycle pulse, coincident with last out_valid of the run
// BEHAVIOUR
//  Reset: FSM=IDLE, counters=0, pipeline valids=0, all outputs 0, twiddle table cleared to 0.
//  Reset mid-run aborts immediately. No done pulse. No out_valid.
//  FSM IDLE->RUN on cfg_en with 1<=cfg_log2n<=MAX_LOG2N. Latches log2n/inverse/scale; clears j,s.
//  cfg_en with out-of-range cfg_log2n is ignored.
//  RUN: each in_valid issues butterfly j (0..2**(log2n-1)-1) of stage s (0..log2n-1).
//  j wraps to 0 and s increments. Issuing j=max at s=log2n-1 moves the FSM to DRAIN.
//  DRAIN->IDLE when the pipeline is empty. done is asserted with the final out_valid.
//  in_valid in IDLE or DRAIN is ignored (no out_valid, counters unchanged).
//  cfg_en in RUN/DRAIN: abort and restart. All in-flight valids are cleared (no out_valid, no done).
//  The new config is latched and the FSM enters RUN.
//  Twiddle index: k = (j & (2**s-1)) << (log2n-1-s), table addr = k << (MAX_LOG2N-log2n).
//  Inverse: W = {re, -im}; -(-32768) saturates to 32767.
//  Pipeline (latency 3, throughput 1/cycle): in_valid at cycle t -> out_valid at t+3.
//   S1: register A,B; synchronous read of tw. S2: 4 products 16x16, re/im sums (33b), >>>15.
//   S3: A±WB (19b), optional >>>1, saturate to [-32768,32767].
//  Shifts are arithmetic, truncating (floor).
//  tw_we is accepted in any state. A write and an S1 read of the same address in the same
//  cycle return the old value.
// CONFIGURATION
//  FFT_BU_ROUND_EN defined: add 2**14 before >>>15 and add 1 before the >>>1 scale
//  (round-half-up). Undefined: pure truncation as above. No other behaviour differs.
// TESTING
//  1 tw[0]=0x7FFF_0000, log2n=1, scale=0, A=0x1000_0000, B=0x0800_0000
//    -> 3 cycles later X=0x17FF_0000, Y=0x0801_0000, done=1.
//    With FFT_BU_ROUND_EN: X=0x1800_0000, Y=0x0800_0000.
//  2 tw[0]=0x7FFF_0000, A=B=0x7FFF_0000: scale=0 -> X=0x7FFF_0000 (sat), Y=0x0001_0000;
//    scale=1 -> X=0x7FFE_0000.
//  3 tw[i]={i<<8,0}, log2n=3, A=0, B=0x4000_0000, 12 in_valid back-to-back -> X.re per issue:
//    stage0 0,0,0,0; stage1 0,0x1000,0,0x1000; stage2 0,0x0800,0x1000,0x1800.
//    done on the 12th out_valid; busy falls next cycle.
//  4 tw[0]=0x0000_7FFF, A=0, B=0x4000_0000: inverse=0 -> X=0x0000_3FFF;
//    inverse=1 -> X=0x0000_C000 (0x0000_C001 with FFT_BU_ROUND_EN).
//  5 cfg_en at cycle 2 of a log2n=2 run, 2 ops in flight -> no out_valid for those ops.
//    New run completes with 4 outputs + done. rst_n low mid-run -> outputs 0 next edge-free, no done.
//  6 in_valid pulses while IDLE -> out_valid stays 0, busy 0.

Source files
------------

// File: rtl/fft_butterfly_r2_if.sv
// fft_butterfly_r2_if: config, twiddle-write, operand and result bundle for the radix-2 butterfly.
interface fft_butterfly_r2_if #(
  parameter int WORD_BITWIDTH = 32,
  parameter int MAX_LOG2N = 7,
  parameter int TW_DEPTH = 2 ** (MAX_LOG2N - 1)
);
  logic cfg_en;
  logic [3:0] cfg_log2n;
  logic cfg_inverse;
  logic cfg_scale;
  logic tw_we;
  logic [$clog2(TW_DEPTH)-1:0] tw_waddr;
  logic [WORD_BITWIDTH-1:0] tw_wdata;
  logic in_valid;
  logic [WORD_BITWIDTH-1:0] in_a;
  logic [WORD_BITWIDTH-1:0] in_b;
  logic out_valid;
  logic [WORD_BITWIDTH-1:0] out_x;
  logic [WORD_BITWIDTH-1:0] out_y;
  logic busy;
  logic done;
  modport master (
    output cfg_en, cfg_log2n, cfg_inverse, cfg_scale, tw_we, tw_waddr, tw_wdata, in_valid, in_a, in_b,
    input out_valid, out_x, out_y, busy, done
  );
  modport slave (
    input cfg_en, cfg_log2n, cfg_inverse, cfg_scale, tw_we, tw_waddr, tw_wdata, in_valid, in_a, in_b,
    output out_valid, out_x, out_y, busy, done
  );
endinterface

// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: 3-stage radix-2 butterfly X=A+W*B, Y=A-W*B with twiddle table and stage sequencer.
// Define FFT_BU_ROUND_EN for round-half-up in the product and scale shifts instead of truncation.
module fft_butterfly_r2 #(
  parameter int WORD_BITWIDTH = 32,
  parameter int MAX_LOG2N = 7,
  parameter int TW_DEPTH = 2 ** (MAX_LOG2N - 1)
) (
  input logic clk,
  input logic rst_n,
  fft_butterfly_r2_if.slave bus
);
  localparam int H = WORD_BITWIDTH / 2;
  localparam int AW = $clog2(TW_DEPTH);
`ifdef FFT_BU_ROUND_EN
  localparam logic signed [2*H:0] RND_P = (2*H+1)'(2 ** (H - 2));
  localparam logic signed [H+2:0] RND_S = (H+3)'(1);
`else
  localparam logic signed [2*H:0] RND_P = '0;
  localparam logic signed [H+2:0] RND_S = '0;
`endif
  localparam logic signed [H-1:0] MAXH = {1'b0, {(H-1){1'b1}}};
  localparam logic signed [H-1:0] MINH = ~MAXH;
  localparam logic signed [H+2:0] SMAX = (H+3)'(2 ** (H - 1) - 1);
  localparam logic signed [H+2:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q;
  logic [3:0] log2n_q, s_q;
  logic inv_q, scale_q, cfg_ok, issue, j_wrap, last;
  logic [AW-1:0] j_q, j_max, tw_addr;
  logic [WORD_BITWIDTH-1:0] tw_mem [TW_DEPTH];
  logic v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
  logic [WORD_BITWIDTH-1:0] a1_q, b1_q, w1_q, a2_q, x_q, y_q, x_d, y_d;
  logic signed [H+1:0] pre_q, pim_q, pre_d, pim_d;
  logic signed [H-1:0] br, bi, wr, wim, wi;
  logic signed [2*H-1:0] prr, pii, pri, pir;
  logic signed [2*H:0] sre, sim;
  function automatic logic [H-1:0] fin(input logic signed [H-1:0] a, input logic signed [H+1:0] p,
                                       input logic sub, input logic sc);
    logic signed [H+2:0] ae, pe, s;
    ae = a;
    pe = p;
    s = sub ? ae - pe : ae + pe;
    s = sc ? (s + RND_S) >>> 1 : s;
    return s > SMAX ? MAXH : s < SMIN ? MINH : s[H-1:0];
  endfunction
  always_comb begin
    cfg_ok = bus.cfg_en && bus.cfg_log2n != 4'd0 && bus.cfg_log2n <= 4'(MAX_LOG2N);
    issue = bus.in_valid && state_q == RUN && !cfg_ok;
    j_max = AW'((32'd1 << (log2n_q - 4'd1)) - 32'd1);
    j_wrap = j_q == j_max;
    last = j_wrap && s_q == log2n_q - 4'd1;
    // (j & (2^s-1)) << (log2n-1-s) scaled to the full-size table collapses to one shift
    tw_addr = AW'((j_q & AW'((32'd1 << s_q) - 32'd1)) << (MAX_LOG2N - 1 - int'(s_q)));
    br = b1_q[WORD_BITWIDTH-1:H];
    bi = b1_q[H-1:0];
    wr = w1_q[WORD_BITWIDTH-1:H];
    wim = w1_q[H-1:0];
    wi = !inv_q ? wim : wim == MINH ? MAXH : -wim;
    prr = br * wr;
    pii = bi * wi;
    pri = br * wi;
    pir = bi * wr;
    sre = {prr[2*H-1], prr} - {pii[2*H-1], pii} + RND_P;
    sim = {pri[2*H-1], pri} + {pir[2*H-1], pir} + RND_P;
    pre_d = (H+2)'(sre >>> (H - 1));
    pim_d = (H+2)'(sim >>> (H - 1));
    x_d = {fin(a2_q[WORD_BITWIDTH-1:H], pre_q, 1'b0, scale_q), fin(a2_q[H-1:0], pim_q, 1'b0, scale_q)};
    y_d = {fin(a2_q[WORD_BITWIDTH-1:H], pre_q, 1'b1, scale_q), fin(a2_q[H-1:0], pim_q, 1'b1, scale_q)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      log2n_q <= '0;
      inv_q <= 1'b0;
      scale_q <= 1'b0;
      j_q <= '0;
      s_q <= '0;
    end else if (cfg_ok) begin
      state_q <= RUN;
      log2n_q <= bus.cfg_log2n;
      inv_q <= bus.cfg_inverse;
      scale_q <= bus.cfg_scale;
      j_q <= '0;
      s_q <= '0;
    end else if (issue) begin
      state_q <= last ? DRAIN : RUN;
      j_q <= j_wrap ? '0 : j_q + 1'b1;
      s_q <= last ? '0 : s_q + 4'(j_wrap);
    end else if (state_q == DRAIN && !v1_q && !v2_q) begin
      state_q <= IDLE;
    end
  end
  // A same-cycle write and S1 read of one address returns the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TW_DEPTH; i++) tw_mem[i] <= '0;
    end else if (bus.tw_we) begin
      tw_mem[bus.tw_waddr] <= bus.tw_wdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q} <= '0;
      {a1_q, b1_q, w1_q, a2_q, x_q, y_q} <= '0;
      pre_q <= '0;
      pim_q <= '0;
    end else begin
      v1_q <= issue;
      v2_q <= v1_q && !cfg_ok;
      v3_q <= v2_q && !cfg_ok;
      l1_q <= last;
      l2_q <= l1_q;
      l3_q <= l2_q;
      a1_q <= bus.in_a;
      b1_q <= bus.in_b;
      w1_q <= tw_mem[tw_addr];
      a2_q <= a1_q;
      pre_q <= pre_d;
      pim_q <= pim_d;
      if (v2_q) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end
  assign bus.out_valid = v3_q;
  assign bus.out_x = x_q;
  assign bus.out_y = y_q;
  assign bus.done = v3_q & l3_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// tb_fft_butterfly_r2: directed vectors with hand-computed results for fft_butterfly_r2.
// Expected values follow FFT_BU_ROUND_EN when it is defined.
module tb_fft_butterfly_r2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
`ifdef FFT_BU_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  fft_butterfly_r2_if bus ();
  fft_butterfly_r2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic [3:0] n, input logic inv, input logic sc);
    bus.cfg_en = 1'b1;
    bus.cfg_log2n = n;
    bus.cfg_inverse = inv;
    bus.cfg_scale = sc;
    @(negedge clk);
    bus.cfg_en = 1'b0;
  endtask
  task automatic tw_wr(input logic [5:0] addr, input logic [31:0] data);
    bus.tw_we = 1'b1;
    bus.tw_waddr = addr;
    bus.tw_wdata = data;
    @(negedge clk);
    bus.tw_we = 1'b0;
  endtask
  task automatic op1(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ex, input logic [31:0] ey);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ov_early"}, 32'(bus.out_valid), 0);
    @(negedge clk);
    check({tag, "_ov"}, 32'(bus.out_valid), 1);
    check({tag, "_x"}, bus.out_x, ex);
    check({tag, "_y"}, bus.out_y, ey);
    check({tag, "_done"}, 32'(bus.done), 1);
    @(negedge clk);
    check({tag, "_busy_end"}, 32'(bus.busy), 0);
    check({tag, "_ov_end"}, 32'(bus.out_valid), 0);
  endtask
  task automatic burst(input string tag, input int n, input logic [31:0] a, input logic [31:0] b);
    for (int c = 0; c < n + 3; c++) begin
      bus.in_valid = c < n;
      bus.in_a = a;
      bus.in_b = b;
      @(negedge clk);
      if (c < 2) begin
        check({tag, "_ov_early"}, 32'(bus.out_valid), 0);
      end else if (c <= n + 1) begin
        check({tag, "_ov"}, 32'(bus.out_valid), 1);
        check({tag, "_x"}, bus.out_x, {exp_q[c-2], 16'h0});
        check({tag, "_done"}, 32'(bus.done), 32'(c == n + 1));
        check({tag, "_busy"}, 32'(bus.busy), 1);
      end else begin
        check({tag, "_ov_end"}, 32'(bus.out_valid), 0);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    {bus.cfg_en, bus.cfg_log2n, bus.cfg_inverse, bus.cfg_scale} = '0;
    {bus.tw_we, bus.tw_waddr, bus.tw_wdata} = '0;
    {bus.in_valid, bus.in_a, bus.in_b} = '0;
    @(negedge clk);
    check("rst_ov", 32'(bus.out_valid), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_x", bus.out_x, 0);
    check("rst_y", bus.out_y, 0);
    rst_n = 1'b1;
    @(negedge clk);
    tw_wr(6'd0, 32'h7FFF_0000);
    cfg(4'd1, 1'b0, 1'b0);
    check("t1_busy", 32'(bus.busy), 1);
    op1("t1", 32'h1000_0000, 32'h0800_0000, RND ? 32'h1800_0000 : 32'h17FF_0000,
        RND ? 32'h0800_0000 : 32'h0801_0000);
    cfg(4'd1, 1'b0, 1'b0);
    op1("t2", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0001_0000);
    cfg(4'd1, 1'b0, 1'b1);
    op1("t2s", 32'h7FFF_0000, 32'h7FFF_0000, RND ? 32'h7FFF_0000 : 32'h7FFE_0000,
        RND ? 32'h0001_0000 : 32'h0000_0000);
    for (int i = 0; i < 64; i++) tw_wr(6'(i), {16'(i << 8), 16'h0});
    cfg(4'd3, 1'b0, 1'b0);
    exp_q = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h1000,
              16'h0, 16'h0800, 16'h1000, 16'h1800};
    burst("t3", 12, 32'h0, 32'h4000_0000);
    tw_wr(6'd0, 32'h0000_7FFF);
    cfg(4'd1, 1'b0, 1'b0);
    op1("t4", 32'h0, 32'h4000_0000, RND ? 32'h0000_4000 : 32'h0000_3FFF,
        RND ? 32'h0000_C000 : 32'h0000_C001);
    cfg(4'd1, 1'b1, 1'b0);
    op1("t4i", 32'h0, 32'h4000_0000, RND ? 32'h0000_C001 : 32'h0000_C000,
        RND ? 32'h0000_3FFF : 32'h0000_4000);
    tw_wr(6'd0, 32'h0000_8000);
    cfg(4'd1, 1'b0, 1'b0);
    op1("t4m", 32'h0, 32'h4000_0000, 32'h0000_C000, 32'h0000_4000);
    cfg(4'd1, 1'b1, 1'b0);
    op1("t4mi", 32'h0, 32'h4000_0000, RND ? 32'h0000_4000 : 32'h0000_3FFF,
        RND ? 32'h0000_C000 : 32'h0000_C001);
    tw_wr(6'd0, 32'h7FFF_0000);
    cfg(4'd2, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a = 32'h0;
    bus.in_b = 32'h4000_0000;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cfg(4'd2, 1'b0, 1'b0);
    check("t5_abort_ov0", 32'(bus.out_valid), 0);
    check("t5_abort_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("t5_abort_ov1", 32'(bus.out_valid), 0);
    check("t5_abort_done", 32'(bus.done), 0);
    if (RND) exp_q = '{16'h4000, 16'h4000, 16'h4000, 16'h1000};
    else exp_q = '{16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h1000};
    burst("t5", 4, 32'h0, 32'h4000_0000);
    cfg(4'd2, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid_ov", 32'(bus.out_valid), 0);
    check("rstmid_busy", 32'(bus.busy), 0);
    check("rstmid_x", bus.out_x, 0);
    check("rstmid_y", bus.out_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid_ov_after", 32'(bus.out_valid), 0);
      check("rstmid_done_after", 32'(bus.done), 0);
    end
    cfg(4'd0, 1'b0, 1'b0);
    check("cfg0_busy", 32'(bus.busy), 0);
    cfg(4'd8, 1'b0, 1'b0);
    check("cfg8_busy", 32'(bus.busy), 0);
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = c < 3;
      bus.in_a = 32'h1234_5678;
      bus.in_b = 32'h4000_0000;
      @(negedge clk);
      check("t6_ov", 32'(bus.out_valid), 0);
      check("t6_busy", 32'(bus.busy), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
